fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch queue between the PC/instruction-memory stage and decode.
//  Each cycle it captures the {PC, instruction} pair read at the current PC and
//  presents pairs to decode in order through a valid/ready handshake.
//  It backpressures the PC through fetch_ready, for example during I/O waits or when decode stalls.
//  A branch or jump redirect discards every queued entry.
// PARAMETERS
//  DEPTH    2    queue entries; power of two, >= 2
//  ADDR_W   32   PC width
//  INSTR_W  32   instruction width
// PORTS
//  CLK           in   1        single clock, rising edge
//  reset         in   1        asynchronous, active-high; clears all state
//  pc_in         in   ADDR_W   current PC (PC register output)
//  instr_in      in   INSTR_W  instruction-memory data at pc_in (same cycle)
//  fetch_valid   in   1        pc_in/instr_in form a valid fetch this cycle
//  fetch_ready   out  1        queue can accept; PC may advance when high
//  flush         in   1        redirect taken; discard queue contents
//  dec_ready     in   1        decode accepts; low while decode stalls or waits on I/O
//  dec_valid     out  1        head entry valid
//  dec_pc        out  ADDR_W   PC of head entry
//  dec_instr     out  INSTR_W  instruction of head entry
//  dec_pc4       out  ADDR_W   dec_pc + 4, modulo 2^ADDR_W
//  dec_line      out  ADDR_W   debug line index = (dec_pc >> 2) + 2
//  count         out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//  - Storage: circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, wrap mod DEPTH) and count.
//  - push = fetch_valid & fetch_ready & ~flush.
//  - pop  = dec_valid & dec_ready.
//  - fetch_ready = (count != DEPTH). It is derived from registered state only, with no path from dec_ready.
//  - dec_valid = (count != 0) & ~flush.
//  - dec_pc, dec_instr, dec_pc4 and dec_line are driven combinationally from the entry at rd_ptr.
//  - Latency: a pair pushed at edge N is visible on dec_* after edge N; there is no same-cycle bypass.
//  - State: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
//    - EMPTY: push -> count 1. Pop is impossible.
//    - PARTIAL: push only -> +1; pop only -> -1; push and pop -> unchanged, both pointers advance.
//    - FULL: push is blocked. Pop -> count DEPTH-1.
//  - Flush (synchronous, highest priority after reset): at the next edge wr_ptr=rd_ptr=count=0.
//    - A push in the same cycle is dropped.
//    - dec_valid is forced low in the flush cycle, so no pop occurs.
//    - Storage contents need not be cleared.
//  - Reset (asynchronous, at any time, including mid-push or mid-flush):
//    - pointers=0 and count=0, so fetch_ready=1 and dec_valid=0.
//    - Storage clears to 0, so dec_pc=0, dec_instr=0, dec_pc4=4 and dec_line=2.
//  - The PC value is never modified. Order is strictly FIFO, and no entry is ever duplicated or lost except on flush.
//  - All arithmetic is unsigned and truncates to ADDR_W.
// STRUCTURE
//  - Shared package mips_pkg holds ADDR_W, INSTR_W, NOP_INSTR (32'h0000_0000) and the
//    fq_state_t encoding {FQ_EMPTY, FQ_PARTIAL, FQ_FULL}.
//  - One sub-module, fetch_queue_mem: DEPTH x (ADDR_W+INSTR_W) register array with one
//    write port and one combinational read port, reset to 0.
//  - Pointer, count and handshake logic stays in fetch_queue.
// TESTING
//  1. Reset: assert reset mid-cycle with count=1. Required immediately: dec_valid=0,
//     fetch_ready=1, count=0, dec_pc=0, dec_line=2.
//  2. Streaming: push pc 0x00,0x04,0x08 with instr 0xA..C and hold dec_ready=1. Required:
//     dec_* shows each pair one cycle after its push, in order, and count stays at 1 throughout.
//  3. Full: hold dec_ready=0 and push 0x10, then 0x14. Required: count=2 and fetch_ready=0.
//     A third push of 0x18 is not accepted. With dec_ready=1, the next three pops return
//     0x10, 0x14 and 0x18, provided 0x18 is re-presented.
//  4. Flush: with count=2, assert flush together with a push of 0x40. Required: dec_valid=0
//     in that cycle; after the edge count=0 and 0x40 is absent.
//  5. Simultaneous push and pop at count=1, pc 0x20 at head and push 0x24. Required: count
//     stays at 1, dec_pc=0x24 after the edge, and dec_pc4=0x28.
//  6. Wrap: run more than 3*DEPTH push/pop cycles with random dec_ready against a scoreboard.
//     Required: zero mismatches, and pc 0xFFFF_FFFC gives dec_pc4=0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: datapath widths, the NOP encoding and fetch-queue occupancy states
// shared by the fetch stage. rev 1.0
package mips_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FQ_EMPTY   = 2'd0,
    FQ_PARTIAL = 2'd1,
    FQ_FULL    = 2'd2
  } fq_state_t;
endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// fetch_queue_if: fetch-side and decode-side handshake bundle of the fetch queue.
// rev 1.0
interface fetch_queue_if #(
  parameter int DEPTH = 2
);
  import mips_pkg::*;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               fetch_valid;
  logic               fetch_ready;
  logic               flush;
  logic               dec_ready;
  logic               dec_valid;
  logic [ADDR_W-1:0]  dec_pc;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc4;
  logic [ADDR_W-1:0]  dec_line;
  logic [CNT_W-1:0]   count;

  modport master (
    output pc_in, instr_in, fetch_valid, flush, dec_ready,
    input  fetch_ready, dec_valid, dec_pc, dec_instr, dec_pc4, dec_line, count
  );

  modport slave (
    input  pc_in, instr_in, fetch_valid, flush, dec_ready,
    output fetch_ready, dec_valid, dec_pc, dec_instr, dec_pc4, dec_line, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// fetch_queue_mem: DEPTH-entry register array, one write port and one
// combinational read port, cleared by reset. rev 1.0
module fetch_queue_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue: in-order {PC, instruction} queue between fetch and decode with
// valid/ready handshake and redirect flush. rev 1.0
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          CLK,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  fq_state_t          w_state;
  logic               w_fetch_ready;
  logic               w_dec_valid;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_rd_data;

  always_comb begin
    w_state = FQ_PARTIAL;
    if (r_count == '0)                      w_state = FQ_EMPTY;
    else if (r_count == CNT_W'(DEPTH))      w_state = FQ_FULL;
  end

  // fetch_ready depends on registered occupancy only, never on dec_ready
  assign w_fetch_ready = (w_state != FQ_FULL);
  assign w_dec_valid   = (w_state != FQ_EMPTY) & ~bus.flush;
  assign w_push        = bus.fetch_valid & w_fetch_ready & ~bus.flush;
  assign w_pop         = w_dec_valid & bus.dec_ready;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case (w_state)
        FQ_EMPTY: begin
          if (w_push) r_count <= CNT_W'(1);
        end
        FQ_PARTIAL: begin
          if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
          else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
        FQ_FULL: begin
          if (w_pop) r_count <= CNT_W'(DEPTH - 1);
        end
        default: r_count <= '0;
      endcase
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .CLK   (CLK),
    .reset (reset),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata ({bus.pc_in, bus.instr_in}),
    .raddr (r_rd_ptr),
    .rdata (w_rd_data)
  );

  assign bus.fetch_ready = w_fetch_ready;
  assign bus.dec_valid   = w_dec_valid;
  assign bus.dec_pc      = w_rd_data[ENTRY_W-1:INSTR_W];
  assign bus.dec_instr   = w_rd_data[INSTR_W-1:0];
  assign bus.dec_pc4     = w_rd_data[ENTRY_W-1:INSTR_W] + ADDR_W'(4);
  assign bus.dec_line    = (w_rd_data[ENTRY_W-1:INSTR_W] >> 2) + ADDR_W'(2);
  assign bus.count       = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue: directed and random stimulus against a queue-based reference
// model; a negedge monitor pops expected pairs as decode accepts them.
module tb_fetch_queue;
  import mips_pkg::*;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  pair_t sb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: occupancy is the scoreboard size; accept/pop decided from it.
  int    sz;
  bit    mv;
  bit    acc;
  pair_t e;
  always @(negedge CLK) begin
    if (!reset) begin
      sz  = sb.size();
      mv  = (sz != 0) && !bus.flush;
      acc = bus.fetch_valid && !bus.flush && (sz != DEPTH);
      chk("count",       32'(bus.count),       32'(sz));
      chk("fetch_ready", 32'(bus.fetch_ready), (sz != DEPTH) ? 32'd1 : 32'd0);
      chk("dec_valid",   32'(bus.dec_valid),   mv ? 32'd1 : 32'd0);
      if (mv && bus.dec_ready) begin
        e = sb.pop_front();
        chk("pop_pc",    bus.dec_pc,    e.pc);
        chk("pop_instr", bus.dec_instr, e.instr);
        chk("pop_pc4",   bus.dec_pc4,   e.pc + 32'd4);
        chk("pop_line",  bus.dec_line,  (e.pc / 32'd4) + 32'd2);
      end
      if (bus.flush) sb.delete();
      else if (acc) sb.push_back('{pc: bus.pc_in, instr: bus.instr_in});
    end
  end

  // Inputs applied just after a rising edge, held for one cycle.
  task automatic cyc(input bit fv, input logic [31:0] pc, input logic [31:0] ins,
                     input bit dr, input bit fl);
    bus.fetch_valid = fv;
    bus.pc_in       = pc;
    bus.instr_in    = ins;
    bus.dec_ready   = dr;
    bus.flush       = fl;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.fetch_valid = 1'b0; bus.pc_in = '0; bus.instr_in = '0;
    bus.dec_ready = 1'b0; bus.flush = 1'b0;
    #1;
    chk("rst0_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst0_ready", 32'(bus.fetch_ready), 32'd1);
    chk("rst0_pc4",   bus.dec_pc4, 32'd4);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;

    // Reset asserted mid-cycle while one entry is held
    cyc(1, 32'h100, 32'h1, 0, 0);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk("pre_rst_count", 32'(bus.count), 32'd1);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    chk("rst_valid", 32'(bus.dec_valid),   32'd0);
    chk("rst_ready", 32'(bus.fetch_ready), 32'd1);
    chk("rst_count", 32'(bus.count),       32'd0);
    chk("rst_pc",    bus.dec_pc,           32'd0);
    chk("rst_instr", bus.dec_instr,        32'd0);
    chk("rst_line",  bus.dec_line,         32'd2);
    chk("rst_pc4",   bus.dec_pc4,          32'd4);
    @(posedge CLK);
    #1 reset = 1'b0;

    // Streaming with decode always ready
    cyc(1, 32'h00, 32'hA, 1, 0);
    chk("stream_head0", bus.dec_pc, 32'h00);
    cyc(1, 32'h04, 32'hB, 1, 0);
    chk("stream_head1", bus.dec_pc, 32'h04);
    cyc(1, 32'h08, 32'hC, 1, 0);
    chk("stream_head2", bus.dec_instr, 32'hC);
    chk("stream_count", 32'(bus.count), 32'd1);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Fill to full, refused push, then drain with re-presented 0x18
    cyc(1, 32'h10, 32'h10, 0, 0);
    cyc(1, 32'h14, 32'h14, 0, 0);
    chk("full_count", 32'(bus.count),       32'd2);
    chk("full_ready", 32'(bus.fetch_ready), 32'd0);
    cyc(1, 32'h18, 32'h18, 0, 0);
    chk("full_hold_pc", bus.dec_pc, 32'h10);
    cyc(1, 32'h18, 32'h18, 1, 0);
    chk("full_pop1", bus.dec_pc, 32'h14);
    cyc(1, 32'h18, 32'h18, 1, 0);
    chk("full_pop2", bus.dec_pc, 32'h18);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("full_drained", 32'(bus.count), 32'd0);

    // Flush with a concurrent push
    cyc(1, 32'h30, 32'h30, 0, 0);
    cyc(1, 32'h34, 32'h34, 0, 0);
    bus.fetch_valid = 1'b1; bus.pc_in = 32'h40; bus.instr_in = 32'h40;
    bus.dec_ready = 1'b1; bus.flush = 1'b1;
    #1;
    chk("flush_valid", 32'(bus.dec_valid), 32'd0);
    @(posedge CLK);
    #1;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid_after", 32'(bus.dec_valid), 32'd0);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk("flush_no40", 32'(bus.count), 32'd0);

    // Simultaneous push and pop at count 1
    cyc(1, 32'h20, 32'h20, 0, 0);
    cyc(1, 32'h24, 32'h24, 1, 0);
    chk("pp_count", 32'(bus.count), 32'd1);
    chk("pp_pc",    bus.dec_pc,     32'h24);
    chk("pp_pc4",   bus.dec_pc4,    32'h28);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // PC wrap boundary
    cyc(1, 32'hFFFF_FFFC, 32'h5, 0, 0);
    chk("wrap_pc4",  bus.dec_pc4,  32'h0);
    chk("wrap_line", bus.dec_line, 32'h4000_0001);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Random traffic, well past several pointer wraps
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, $urandom, $urandom,
          ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    for (int i = 0; i < 2 * DEPTH + 2; i++) cyc(0, 32'h0, 32'h0, 1, 0);
    chk("final_count", 32'(bus.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
